// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that shares one spi_master_tx between NREQ byte producers.
// One transfer in flight at a time; a master that never raises busy is aborted with err.
module spi_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic [7:0]              data_in,
  output logic                    master_send,
  input  logic                    m_busy,
  output logic [1:0]              dbg_state,
  output logic [$clog2(NREQ)-1:0] dbg_ptr
);
  // Handshakes: a requester holds req[i] and its byte until grant[i] pulses; the byte is
  // captured on that edge. master_send stays high until m_busy is sampled high, and the
  // transfer is complete when m_busy is next sampled low (done pulses one cycle later).

  localparam int PW = $clog2(NREQ);
  localparam int IW = PW + 1;
  localparam int CW = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_cur;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [7:0]      r_data;
  logic            r_send;

  logic [7:0]      w_bytes [NREQ];
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [IW-1:0]   w_idx;
  logic [PW-1:0]   w_ptr_next;
  logic [NREQ-1:0] w_win_onehot;
  logic [NREQ-1:0] w_cur_onehot;

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // Scan from the highest offset down so the first set bit at or after r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + IW'(i);
      if (w_idx >= IW'(NREQ)) begin
        w_idx = w_idx - IW'(NREQ);
      end
      if (req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

  assign w_ptr_next   = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_win_onehot = NREQ'(1) << w_win;
  assign w_cur_onehot = NREQ'(1) << r_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_send  <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !m_busy) begin
            r_data  <= w_bytes[w_win];
            r_send  <= 1'b1;
            r_grant <= w_win_onehot;
            r_cur   <= w_win;
            r_ptr   <= w_ptr_next;
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_busy) begin
            r_send  <= 1'b0;
            r_state <= ST_BUSY;
          end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
            r_send  <= 1'b0;
            r_done  <= w_cur_onehot;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (!m_busy) begin
            r_done  <= w_cur_onehot;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign err         = r_err;
  assign data_in     = r_data;
  assign master_send = r_send;
  assign dbg_state   = r_state;
  assign dbg_ptr     = r_ptr;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: behavioural SPI master, transaction-level reference model,
// scoreboard queues checked by a negedge monitor, directed scenarios plus random traffic.
module tb_spi_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic            err;
  logic [7:0]      data_in;
  logic            master_send;
  logic            m_busy = 1'b0;
  logic [1:0]      dbg_state;
  logic [1:0]      dbg_ptr;

  spi_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .done(done),
    .err(err), .data_in(data_in), .master_send(master_send), .m_busy(m_busy),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries: {cycle[31:0], requester[7:0], byte-or-err[7:0]}
  logic [47:0] exp_grant_q[$];
  logic [47:0] exp_done_q[$];
  int m_ptr = 0;
  int m_phase = 0;  // 0 waiting for work, 1 waiting for master start, 2 master running
  int m_owner = 0;
  int m_cnt = 0;
  int m_w = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ptr   = 0;
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (req != '0 && !m_busy) begin
          m_w = -1;
          for (int i = 0; i < NREQ; i++)
            if (m_w < 0 && req[(m_ptr + i) % NREQ]) m_w = (m_ptr + i) % NREQ;
          exp_grant_q.push_back({32'(cyc), 8'(m_w), req_data[8*m_w +: 8]});
          m_owner = m_w;
          m_ptr   = (m_w + 1) % NREQ;
          m_cnt   = 0;
          m_phase = 1;
        end
        1: if (m_busy) m_phase = 2;
           else begin
             m_cnt++;
             if (m_cnt == TO) begin
               exp_done_q.push_back({32'(cyc), 8'(m_owner), 8'd1});
               m_phase = 0;
             end
           end
        2: if (!m_busy) begin
          exp_done_q.push_back({32'(cyc), 8'(m_owner), 8'd0});
          m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- behavioural spi master ----------------
  bit hang = 0;
  bit rnd_hang = 0;
  bit force_busy = 0;
  int ms = 0;
  int dly = 0;
  int len = 0;
  logic [7:0] rx_q[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_busy = 1'b0;
        ms = 0;
      end else if (force_busy) begin
        m_busy = 1'b1;
        ms = 5;
      end else begin
        case (ms)
          0: if (master_send) begin
            if (hang || (rnd_hang && $urandom_range(0, 7) == 0)) ms = 4;
            else begin
              dly = $urandom_range(0, 3);
              ms = 1;
            end
          end
          1: if (dly == 0) begin
            m_busy = 1'b1;
            rx_q.push_back(data_in);
            len = $urandom_range(2, 12);
            ms = 2;
          end else dly--;
          2: if (len == 0) begin
            m_busy = 1'b0;
            ms = 0;
          end else len--;
          4: if (!master_send) ms = 0;
          5: begin
            m_busy = 1'b0;
            ms = 0;
          end
          default: ms = 0;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [47:0] mon_e;
  logic [7:0]  last_byte = '0;
  int grant_log[$];
  int done_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (grant != '0) begin
        if (exp_grant_q.size() == 0) check(1'b0, "grant_unexpected", grant, 0);
        else begin
          mon_e = exp_grant_q.pop_front();
          check(grant == (4'b1 << mon_e[15:8]), "grant_onehot", grant, 4'b1 << mon_e[15:8]);
          check(mon_e[47:16] == 32'(cyc), "grant_cycle", cyc, mon_e[47:16]);
          check(data_in == mon_e[7:0], "grant_data", data_in, mon_e[7:0]);
          check(master_send == 1'b1, "send_on_grant", master_send, 1);
          last_byte = mon_e[7:0];
          grant_log.push_back(int'(mon_e[15:8]));
        end
      end else if (exp_grant_q.size() != 0 && exp_grant_q[0][47:16] <= 32'(cyc)) begin
        check(1'b0, "grant_missing", 0, exp_grant_q[0][15:8]);
        void'(exp_grant_q.pop_front());
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) check(1'b0, "done_unexpected", done, 0);
        else begin
          mon_e = exp_done_q.pop_front();
          check(done == (4'b1 << mon_e[15:8]), "done_onehot", done, 4'b1 << mon_e[15:8]);
          check(mon_e[47:16] == 32'(cyc), "done_cycle", cyc, mon_e[47:16]);
          check(err == mon_e[0], "done_err", err, mon_e[0]);
          done_log.push_back(int'(mon_e[15:8]));
        end
      end else if (exp_done_q.size() != 0 && exp_done_q[0][47:16] <= 32'(cyc)) begin
        check(1'b0, "done_missing", 0, exp_done_q[0][15:8]);
        void'(exp_done_q.pop_front());
      end
      if (err && done == '0) check(1'b0, "err_without_done", err, 0);
      if (master_send && grant == '0) check(data_in == last_byte, "data_hold", data_in, last_byte);
    end
  end

  // ---------------- requester driver ----------------
  logic [NREQ-1:0] hold_mask = '0;
  logic [NREQ-1:0] reraise = '0;
  bit rnd_req = 0;

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        req[i] = 1'b0;
        reraise[i] = hold_mask[i];
      end else if (reraise[i]) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
        reraise[i] = 1'b0;
      end else if (rnd_req && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic raise(input int i, input logic [7:0] b);
    req[i] = 1'b1;
    req_data[8*i +: 8] = b;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int t = 0; t < budget && quiet < 3; t++) begin
      step();
      if (m_phase == 0 && req == '0 && reraise == '0 && !m_busy) quiet++;
      else quiet = 0;
    end
    check(quiet >= 3, "idle_wait", quiet, 3);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] sim_bytes[4] = '{8'h01, 8'h55, 8'hAA, 8'hFF};
    int fair_order[6] = '{0, 3, 0, 3, 0, 3};
    int c0;
    int cnt;
    int n_g;
    bit seen;

    // reset state
    repeat (3) step();
    check(grant == '0 && done == '0 && err == 1'b0, "reset_pulses", {grant, done, err}, 0);
    check(data_in == 8'h00 && master_send == 1'b0, "reset_master_if", {data_in, master_send}, 0);
    check(dbg_state == 2'd0 && dbg_ptr == 2'd0, "reset_fsm", {dbg_state, dbg_ptr}, 0);
    rst = 1'b0;
    repeat (3) step();

    // simultaneous requests
    grant_log.delete(); done_log.delete(); rx_q.delete();
    for (int i = 0; i < NREQ; i++) raise(i, sim_bytes[i]);
    wait_idle(400);
    check(grant_log.size() == 4, "simul_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check(grant_log[i] == i, "simul_grant_order", grant_log[i], i);
    check(rx_q.size() == 4, "simul_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++)
      check(rx_q[i] == sim_bytes[i], "simul_rx_byte", rx_q[i], sim_bytes[i]);
    check(done_log.size() == 4, "simul_done_count", done_log.size(), 4);
    check(dbg_ptr == 2'd0, "simul_ptr_wrap", dbg_ptr, 0);

    // fairness between requesters 0 and 3
    grant_log.delete();
    hold_mask = 4'b1001;
    raise(0, 8'h10);
    raise(3, 8'h30);
    for (int t = 0; t < 600 && grant_log.size() < 6; t++) step();
    hold_mask = '0;
    wait_idle(400);
    check(grant_log.size() >= 6, "fair_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check(grant_log[i] == fair_order[i], "fair_order", grant_log[i], fair_order[i]);

    // single request on requester 2
    grant_log.delete(); done_log.delete(); rx_q.delete();
    raise(2, 8'hA5);
    c0 = cyc;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      step();
      if (grant != '0) begin
        seen = 1;
        check(grant == 4'b0100, "single_grant", grant, 4'b0100);
        check(cyc == c0 + 1, "single_latency", cyc - c0, 1);
      end
    end
    check(seen, "single_grant_seen", seen, 1);
    wait_idle(200);
    check(rx_q.size() == 1 && rx_q[0] == 8'hA5, "single_rx", rx_q.size() == 1 ? rx_q[0] : 8'h00, 8'hA5);
    check(done_log.size() == 1, "single_done_once", done_log.size(), 1);

    // start timeout
    hang = 1;
    raise(1, 8'h77);
    cnt = 0;
    seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      step();
      if (done != '0) begin
        seen = 1;
        check(done == 4'b0010 && err == 1'b1, "timeout_done_err", {done, err}, {4'b0010, 1'b1});
        check(dbg_state == 2'd0, "timeout_idle", dbg_state, 0);
      end else if (master_send) cnt++;
    end
    check(seen, "timeout_seen", seen, 1);
    check(cnt == TO, "timeout_send_cycles", cnt, TO);
    step();
    check(err == 1'b0 && done == '0, "timeout_pulse_width", {done, err}, 0);
    hang = 0;
    wait_idle(100);

    // m_busy blocks arbitration; a request dropped before its grant is never served
    force_busy = 1;
    repeat (2) step();
    raise(0, 8'h5A);
    raise(3, 8'hC3);
    n_g = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (grant != '0) n_g++;
      if (t == 10) req[3] = 1'b0;
    end
    check(n_g == 0, "busy_block_no_grant", n_g, 0);
    force_busy = 0;
    seen = 0;
    for (int t = 0; t < 6 && !seen; t++) begin
      step();
      if (!m_busy) seen = 1;
    end
    c0 = cyc;
    step();
    check(grant == 4'b0001, "busy_release_grant", grant, 4'b0001);
    check(cyc == c0 + 1, "busy_release_latency", cyc - c0, 1);
    wait_idle(200);

    // random traffic, including random master stalls that time out
    grant_log.delete(); done_log.delete();
    rnd_req = 1;
    rnd_hang = 1;
    repeat (500) step();
    rnd_req = 0;
    wait_idle(600);
    rnd_hang = 0;
    check(grant_log.size() == done_log.size(), "random_grant_done_balance",
          grant_log.size(), done_log.size());
    check(grant_log.size() > 10, "random_activity", grant_log.size(), 11);

    // asynchronous reset in BUSY
    raise(2, 8'h3C);
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step();
      if (m_phase == 2) seen = 1;
    end
    check(seen, "rst_reach_busy", seen, 1);
    rst = 1'b1;
    #1;
    check(grant == '0 && done == '0 && err == 1'b0, "rst_async_pulses", {grant, done, err}, 0);
    check(data_in == 8'h00 && master_send == 1'b0, "rst_async_master_if", {data_in, master_send}, 0);
    check(dbg_state == 2'd0 && dbg_ptr == 2'd0, "rst_async_fsm", {dbg_state, dbg_ptr}, 0);
    repeat (2) step();
    rst = 1'b0;
    done_log.delete();
    repeat (15) step();
    check(done_log.size() == 0, "rst_no_done", done_log.size(), 0);
    raise(1, 8'h96);
    c0 = cyc;
    step();
    check(grant == 4'b0010, "rst_next_grant", grant, 4'b0010);
    check(cyc == c0 + 1, "rst_next_latency", cyc - c0, 1);
    check(dbg_ptr == 2'd2, "rst_ptr_after_grant", dbg_ptr, 2);
    wait_idle(200);

    check(exp_grant_q.size() == 0, "grant_queue_drained", exp_grant_q.size(), 0);
    check(exp_done_q.size() == 0, "done_queue_drained", exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin arbiter that shares one `spi_master_tx` between `NREQ` byte-producing requesters. It accepts one byte per grant, drives the master's `data_in`/`master_send` inputs, and tracks the master's `busy` through one complete transfer. When the master goes idle again, it reports completion to the owning requester. It also detects a master that never starts a transfer and reports that as an error.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 16: cycles allowed in SEND for `m_busy` to rise before aborting; must be ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  level request per requester.
- `req_data`  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- `grant`  out  NREQ  one-hot, 1-cycle pulse: requester's byte captured.
- `done`  out  NREQ  one-hot, 1-cycle pulse: requester's transfer finished or aborted.
- `err`  out  1  1-cycle pulse, coincident with `done`, when the transfer was aborted by timeout.
- `data_in`  out  8  byte presented to `spi_master_tx`.
- `master_send`  out  1  send request to `spi_master_tx`.
- `m_busy`  in  1  busy flag from `spi_master_tx`.

## Operation
- Reset values:
  - `grant`=0, `done`=0, `err`=0.
  - `data_in`=0, `master_send`=0.
  - State=IDLE, round-robin pointer `ptr`=0, timeout counter=0.
- States and transitions:
  - IDLE. If `req`≠0 and `m_busy`=0, pick a winner `w`: the first set bit of `req` scanning `ptr`, `ptr+1`, … mod NREQ. On the next edge:
    - `data_in` ← `req_data[w]`; `master_send` ← 1.
    - `grant[w]` ← 1 for one cycle.
    - `cur` ← `w`; `ptr` ← (`w`+1) mod NREQ; counter ← 0; go to SEND.
  - IDLE, no start. If `req`=0 or `m_busy`=1, stay in IDLE; outputs unchanged except pulses, which return to 0.
  - SEND. Hold `master_send`=1 and `data_in` stable.
    - `m_busy`=1 sampled: `master_send` ← 0; go to BUSY.
    - Otherwise, if counter = START_TIMEOUT−1: `master_send` ← 0, `done[cur]` ← 1, `err` ← 1; go to IDLE.
    - Otherwise the counter increments.
  - BUSY. Wait for `m_busy`=0. When sampled: `done[cur]` ← 1, `err` ← 0; go to IDLE.
- `data_in` keeps its last value outside SEND; it is not cleared.
- Requester protocol:
  - Raise `req[i]` with `req_data[i]` valid, and hold both until `grant[i]` is seen.
  - Drop `req[i]` in the cycle after `grant[i]`.
  - A `req[i]` still high in IDLE is a new request.
  - A request dropped before its grant is never served and produces no pulses.
- Exactly one transfer is in flight at a time; at most one bit of `grant`, `done` is ever set.
- Counter width is $clog2(START_TIMEOUT); no wrap occurs, because it is cleared on every grant.
- Round-robin: a requester that just received a grant has the lowest priority in the next arbitration. With all requests continuously asserted, grants cycle 0,1,…,NREQ−1,0,…

## Timing
- `req` high at edge k with IDLE and `m_busy`=0 → `grant`, `master_send`, `data_in` valid after edge k (visible in cycle k+1).
- `m_busy` rise sampled at edge j → `master_send` low after edge j.
- `m_busy` fall sampled at edge d → `done` high for cycle d+1. The next grant is no earlier than the edge after that (one idle cycle minimum between transfers).
- Timeout:
  - `grant` after edge k and `m_busy` never rises → `master_send` stays high for exactly START_TIMEOUT cycles.
  - `done` and `err` then pulse together in the cycle after the final SEND cycle.
- `m_busy` high in IDLE (e.g. master still draining after an abort) blocks arbitration; requests wait and no grant is issued until `m_busy`=0 is sampled.
- Asynchronous `rst` mid-transfer: all outputs go to reset values immediately and `ptr`=0. The interrupted requester receives no `done`. After release, arbitration resumes on the first edge at which `rst`=0.
- Simultaneous `req` rise and `done`: that `done` cycle is still IDLE-bound, so the new request is granted at the next IDLE evaluation.

## Test plan
- Single request: `req[2]`=1, `req_data[2]`=8'hA5, with a real `spi_master_tx`/`spi_slave_rx` pair.
  - `grant`=4'b0100 one cycle after `req`.
  - Slave `data_out`=8'hA5.
  - `done`=4'b0100 exactly once, `err`=0.
- Simultaneous requests: `req`=4'b1111 held, each requester dropping after its grant, bytes 8'h01/8'h55/8'hAA/8'hFF.
  - Grant order 0,1,2,3.
  - Slave receives 01,55,AA,FF.
  - Four `done` pulses; `ptr` returns to 0.
- Fairness: `req[0]`,`req[3]` held continuously, re-asserted after every grant, for 6 transfers → grants alternate 0,3,0,3,0,3.
- Timeout: `m_busy` tied 0, `req[1]`=1.
  - `master_send` high for exactly 16 cycles.
  - Then `done`=4'b0010 and `err`=1 for one cycle.
  - Back in IDLE.
- Busy blocking: hold `m_busy`=1 for 20 cycles with `req[0]`=1 → no `grant` during those cycles; `grant[0]` one cycle after `m_busy` is sampled low.
- Reset mid-transfer: assert `rst` while in BUSY.
  - All outputs 0 immediately; no `done` for the interrupted requester.
  - A following `req[1]` is granted normally with `ptr` starting from 0.
